// File: rtl/debug_slave_pkg.sv
// Shared definitions for the CPU JTAG debug slave: command layout,
// IR channel encodings and the default action-select bit.
package debug_slave_pkg;

   localparam int DEFAULT_DATA_W  = 38;
   localparam int DEFAULT_IR_W    = 2;
   localparam int ACT_BIT_DEFAULT = 35;

   typedef enum logic [1:0] {
      CH_OCIMEM    = 2'd0,
      CH_TRACEMEM  = 2'd1,
      CH_BREAK     = 2'd2,
      CH_TRACECTRL = 2'd3
   } debug_ch_e;

   typedef struct packed {
      logic [DEFAULT_IR_W-1:0]   ch;
      logic [DEFAULT_DATA_W-1:0] data;
   } debug_cmd_t;

endpackage

// File: rtl/debug_toggle_sync.sv
// Three-flop synchroniser for a TCK-domain toggle line. The pulse output
// is high for one sysclk cycle after each flip of the toggle.
module debug_toggle_sync (
   input  logic clk,
   input  logic tgl,
   output logic pulse
);

   logic s1, s2, s3;

   // Shift chain deliberately has no reset so it keeps tracking the toggle
   // while the decoder is held in reset.
   always_ff @(posedge clk) begin
      s1 <= tgl;
      s2 <= s1;
      s3 <= s2;
   end

   assign pulse = s2 ^ s3;

endmodule

// File: rtl/debug_cmd_sysclk_decoder.sv
// Sysclk-side command decoder for the JTAG debug slave. Update-IR and
// update-DR events arrive as toggles, captured commands are queued in a
// small FIFO, and each popped command produces a per-channel action or
// no-action pulse together with a held data word.
module debug_cmd_sysclk_decoder
   import debug_slave_pkg::*;
#(
   parameter int  DATA_W  = DEFAULT_DATA_W,
   parameter int  IR_W    = DEFAULT_IR_W,
   parameter int  DEPTH   = 4,
   parameter int  ACT_BIT = ACT_BIT_DEFAULT,
   localparam int NUM_CH  = 2**IR_W,
   localparam int LVL_W   = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sr,
   input  logic [IR_W-1:0]   ir_in,
   input  logic              uir_tgl,
   input  logic              udr_tgl,
   input  logic              cmd_ready,
   input  logic              clr_overflow,
   output logic              cmd_valid,
   output logic [IR_W-1:0]   cmd_ch,
   output logic [DATA_W-1:0] jdo,
   output logic [NUM_CH-1:0] take_action,
   output logic [NUM_CH-1:0] take_no_action,
   output logic              overflow,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam int AW = $clog2(DEPTH);

   logic              uir_pulse, udr_pulse;
   logic [1:0]        guard_cnt;
   logic              armed;
   logic              uir_evt, udr_evt;
   logic [IR_W-1:0]   ir_q;
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [IR_W-1:0]   ch_mem   [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              full, pop, push, drop;
   logic [DATA_W-1:0] head_data;
   logic [NUM_CH-1:0] head_onehot;

   debug_toggle_sync u_uir_sync (
      .clk   (clk),
      .tgl   (uir_tgl),
      .pulse (uir_pulse)
   );

   debug_toggle_sync u_udr_sync (
      .clk   (clk),
      .tgl   (udr_tgl),
      .pulse (udr_pulse)
   );

   assign armed       = (guard_cnt == 2'd0);
   assign uir_evt     = uir_pulse & armed;
   assign udr_evt     = udr_pulse & armed;
   assign cmd_valid   = (fifo_level != '0);
   assign full        = (fifo_level == LVL_W'(DEPTH));
   assign pop         = cmd_valid & cmd_ready;
   assign push        = udr_evt & (~full | pop);
   assign drop        = udr_evt & full & ~pop;
   assign head_data   = data_mem[rd_ptr];
   assign cmd_ch      = ch_mem[rd_ptr];
   assign head_onehot = NUM_CH'(1) << cmd_ch;

   // Guard counter masks synchroniser edges for three cycles after reset.
   always_ff @(posedge clk) begin
      if (reset)
         guard_cnt <= 2'd3;
      else if (guard_cnt != 2'd0)
         guard_cnt <= guard_cnt - 2'd1;
   end

   // Latch the IR on each update-IR event; a same-cycle push sees the old value.
   always_ff @(posedge clk) begin
      if (reset)
         ir_q <= '0;
      else if (uir_evt)
         ir_q <= ir_in;
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= sr;
         ch_mem[wr_ptr]   <= ir_q;
      end
   end

   // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_level <= fifo_level + 1'b1;
         else if (pop && !push)
            fifo_level <= fifo_level - 1'b1;
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

   // On a pop, hold the head data on jdo and fire one pulse on the head's channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         if (pop) begin
            jdo <= head_data;
            if (head_data[ACT_BIT])
               take_action <= head_onehot;
            else
               take_no_action <= head_onehot;
         end
      end
   end

endmodule

// File: tb/tb_debug_cmd_sysclk_decoder.sv
// Randomised self-checking bench for debug_cmd_sysclk_decoder. A queue of
// commands models the decoder at transaction level: each update event is
// allowed to settle before outputs are compared against the queue.
module tb_debug_cmd_sysclk_decoder;
   import debug_slave_pkg::*;

   localparam int DATA_W  = 38;
   localparam int IR_W    = 2;
   localparam int DEPTH   = 4;
   localparam int ACT_BIT = 35;
   localparam int NUM_CH  = 4;
   localparam int LVL_W   = 3;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] sr;
   logic [IR_W-1:0]   ir_in;
   logic              uir_tgl;
   logic              udr_tgl;
   logic              cmd_ready;
   logic              clr_overflow;
   logic              cmd_valid;
   logic [IR_W-1:0]   cmd_ch;
   logic [DATA_W-1:0] jdo;
   logic [NUM_CH-1:0] take_action;
   logic [NUM_CH-1:0] take_no_action;
   logic              overflow;
   logic [LVL_W-1:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   debug_cmd_t        model_q[$];
   logic [IR_W-1:0]   model_ir;
   logic              model_ovf;
   logic [DATA_W-1:0] model_jdo;

   debug_cmd_sysclk_decoder #(
      .DATA_W  (DATA_W),
      .IR_W    (IR_W),
      .DEPTH   (DEPTH),
      .ACT_BIT (ACT_BIT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sr             (sr),
      .ir_in          (ir_in),
      .uir_tgl        (uir_tgl),
      .udr_tgl        (udr_tgl),
      .cmd_ready      (cmd_ready),
      .clr_overflow   (clr_overflow),
      .cmd_valid      (cmd_valid),
      .cmd_ch         (cmd_ch),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .overflow       (overflow),
      .fifo_level     (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compare queue occupancy, overflow and head channel with the model.
   task automatic check_state(input string tag);
      check_output({tag, " level"}, 64'(fifo_level), 64'(model_q.size()));
      check_output({tag, " valid"}, 64'(cmd_valid), 64'(model_q.size() != 0));
      check_output({tag, " overflow"}, 64'(overflow), 64'(model_ovf));
      if (model_q.size() != 0)
         check_output({tag, " cmd_ch"}, 64'(cmd_ch), 64'(model_q[0].ch));
   endtask

   // Model of an update-DR arrival: queued if room, else counted as overflow.
   task automatic model_push(input logic [DATA_W-1:0] d);
      debug_cmd_t c;
      if (model_q.size() == DEPTH) begin
         model_ovf = 1'b1;
      end else begin
         c.ch   = model_ir;
         c.data = d;
         model_q.push_back(c);
      end
   endtask

   // Called just after the clock edge that performed a pop request.
   task automatic check_pop_result(input string tag);
      debug_cmd_t        c;
      logic [NUM_CH-1:0] exp_act, exp_noact;
      exp_act   = '0;
      exp_noact = '0;
      if (model_q.size() != 0) begin
         c = model_q.pop_front();
         model_jdo = c.data;
         if (c.data[ACT_BIT])
            exp_act[c.ch] = 1'b1;
         else
            exp_noact[c.ch] = 1'b1;
      end
      check_output({tag, " jdo"}, 64'(jdo), 64'(model_jdo));
      check_output({tag, " take_action"}, 64'(take_action), 64'(exp_act));
      check_output({tag, " take_no_action"}, 64'(take_no_action), 64'(exp_noact));
   endtask

   task automatic apply_ir(input logic [IR_W-1:0] v);
      @(negedge clk);
      ir_in   = v;
      uir_tgl = ~uir_tgl;
      model_ir = v;
      repeat (5) @(negedge clk);
   endtask

   task automatic apply_dr(input logic [DATA_W-1:0] d);
      @(negedge clk);
      sr      = d;
      udr_tgl = ~udr_tgl;
      model_push(d);
      repeat (5) @(negedge clk);
      check_state("dr");
   endtask

   // Update-IR and update-DR flip together: the push keeps the previous IR.
   task automatic apply_both(input logic [IR_W-1:0] v, input logic [DATA_W-1:0] d);
      @(negedge clk);
      ir_in   = v;
      sr      = d;
      uir_tgl = ~uir_tgl;
      udr_tgl = ~udr_tgl;
      model_push(d);
      model_ir = v;
      repeat (5) @(negedge clk);
      check_state("both");
   endtask

   task automatic apply_pop();
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check_pop_result("pop");
      @(negedge clk);
      check_output("pulse_gone act", 64'(take_action), 64'd0);
      check_output("pulse_gone noact", 64'(take_no_action), 64'd0);
      check_state("pop");
   endtask

   // Update-DR edge arriving in the same cycle as a pop on a full queue.
   task automatic apply_push_pop_full(input logic [DATA_W-1:0] d);
      @(negedge clk);
      sr      = d;
      udr_tgl = ~udr_tgl;
      @(negedge clk);
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check_pop_result("fullpp");
      model_push(d);
      repeat (4) @(negedge clk);
      check_state("fullpp");
   endtask

   task automatic apply_clr();
      @(negedge clk);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      model_ovf = 1'b0;
      check_state("clr");
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [63:0] tmp;
      tmp = {$urandom(), $urandom()};
      return tmp[DATA_W-1:0];
   endfunction

   initial begin
      reset        = 1'b1;
      sr           = '0;
      ir_in        = '0;
      uir_tgl      = 1'b0;
      udr_tgl      = 1'b1;
      cmd_ready    = 1'b0;
      clr_overflow = 1'b0;
      model_ir     = '0;
      model_ovf    = 1'b0;
      model_jdo    = '0;

      // Reset release with the DR toggle already high must not push.
      repeat (4) @(negedge clk);
      reset = 1'b0;
      check_output("rst jdo", 64'(jdo), 64'd0);
      check_output("rst take_action", 64'(take_action), 64'd0);
      check_output("rst take_no_action", 64'(take_no_action), 64'd0);
      check_state("rst");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output("post_rst level", 64'(fifo_level), 64'd0);
      end

      // Single action command on the break channel.
      apply_ir(CH_BREAK);
      apply_dr(38'h08_0000_0001);
      apply_pop();

      // Fill past depth, then drain in order.
      apply_ir(CH_TRACEMEM);
      for (int i = 0; i < 5; i++) begin
         logic [DATA_W-1:0] d;
         d = DATA_W'(i + 16);
         d[ACT_BIT] = (i % 2 == 1);
         apply_dr(d);
      end
      check_output("ovf level", 64'(fifo_level), 64'd4);
      check_output("ovf flag", 64'(overflow), 64'd1);
      for (int i = 0; i < 4; i++) apply_pop();
      apply_clr();

      // Full queue with simultaneous push and pop: no overflow.
      apply_ir(CH_OCIMEM);
      for (int i = 0; i < 4; i++) apply_dr(rand_data());
      apply_push_pop_full(38'h08_1234_5678);
      check_output("fullpp level", 64'(fifo_level), 64'd4);
      check_output("fullpp ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 4; i++) apply_pop();

      // Same-cycle IR and DR updates.
      apply_ir(CH_TRACEMEM);
      apply_both(CH_TRACECTRL, 38'h00_0000_00AA);
      check_output("both head ch", 64'(cmd_ch), 64'd1);
      apply_dr(38'h08_0000_00BB);
      apply_pop();
      check_output("both next ch", 64'(cmd_ch), 64'd3);
      apply_pop();

      // Mid-operation reset with three entries queued.
      for (int i = 0; i < 3; i++) apply_dr(rand_data());
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_output("midrst valid", 64'(cmd_valid), 64'd0);
      check_output("midrst level", 64'(fifo_level), 64'd0);
      check_output("midrst act", 64'(take_action), 64'd0);
      check_output("midrst noact", 64'(take_no_action), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      model_q.delete();
      model_ir  = '0;
      model_ovf = 1'b0;
      model_jdo = '0;
      repeat (5) @(negedge clk);
      check_output("midrst jdo", 64'(jdo), 64'd0);
      check_state("midrst");

      // Randomised mix of IR updates, pushes, pops and overflow clears.
      for (int n = 0; n < 80; n++) begin
         int unsigned r;
         r = $urandom_range(0, 9);
         if (r < 2)
            apply_ir(IR_W'($urandom_range(0, NUM_CH - 1)));
         else if (r < 6)
            apply_dr(rand_data());
         else if (r < 9)
            apply_pop();
         else
            apply_clr();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
